// File: rtl/interval_timer_pkg.sv
// Shared types and constants for the interval timer controller.
package interval_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/load_counter.sv
// Loadable WIDTH-bit up-counter; load wins over enable, wraps modulo 2^WIDTH.
module load_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  // Count register: reset, then load, then increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller: sequences load_counter, emits ticks.
module interval_timer_ctrl
  import interval_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic             cfg_periodic_i,
  input  logic             pause_i,
  input  logic             stop_i,
  output logic             busy_o,
  output logic             tick_o,
  output logic             err_o,
  output logic [WIDTH-1:0] count_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             periodic_q, periodic_d;
  logic             err_q, err_d;
  logic             cnt_load, cnt_en;
  logic [WIDTH-1:0] count;
  logic             terminal;

  load_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val ('0),
    .count    (count)
  );

  // period_q >= 1 whenever RUN/HOLD is reachable, so the subtraction never wraps there.
  assign terminal    = (count == period_q - WIDTH'(1));
  assign tick_o      = (state_q == RUN) & terminal & ~pause_i & ~stop_i;
  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == RUN) | (state_q == HOLD);
  assign err_o       = err_q;
  assign count_o     = count;

  // Next-state, capture and counter control decode.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    err_d      = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          period_d   = cfg_period_i;
          periodic_d = cfg_periodic_i;
          if (cfg_period_i != '0) begin
            cnt_load = 1'b1;
            state_d  = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (pause_i) begin
          state_d = HOLD;
        end else if (terminal) begin
          if (periodic_q == MODE_PERIODIC) begin
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      HOLD: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (!pause_i) begin
          state_d = RUN;
          // The release cycle counts as a run cycle so each paused cycle costs exactly
          // one cycle of delay; a held terminal value is left alone so its tick still fires.
          cnt_en  = ~terminal;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured configuration and error pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      period_q   <= '0;
      periodic_q <= MODE_ONESHOT;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      err_q      <= err_d;
    end
  end

endmodule
